// File: rtl/pipeline_hazard_scoreboard.sv
// pipeline_hazard_scoreboard
// ----------------------------------------------------------------------------
// ID-stage hazard unit built around a per-register scoreboard. Each tracked
// destination register carries a down-counter holding the number of cycles
// left before its value can be consumed by an instruction sitting in ID.
// The latency loaded into a counter depends on the operation class of the
// producing instruction (ALU, load, long multi-cycle op). A separate counter
// models occupancy of the single, non-pipelined long unit.
//
// The unit raises stall_o on read-after-write, write-after-write and
// structural (long unit busy) hazards. It produces issue_o, the advance strobe
// for the ID/EX register. A saturating counter records how many cycles stalled.
//
// Parameters
//   ADDR_W   register address width (NUM_REGS = 2**ADDR_W)
//   ALU_LAT  cycles until an ALU result is usable in ID (0 = fully forwarded)
//   LOAD_LAT cycles until a load result is usable in ID
//   LONG_LAT cycles until a long-op result is usable in ID, and long unit
//            occupancy
//   CNT_W    width of the stall-cycle performance counter
//
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   id_valid_i      ID holds a valid instruction
//   rs1_addr_i      source 1 register address
//   rs2_addr_i      source 2 register address
//   rs1_used_i      source 1 is actually read
//   rs2_used_i      source 2 is actually read
//   rd_addr_i       destination register address
//   reg_write_i     instruction writes rd
//   op_class_i      0 = ALU, 1 = load, 2 = long, 3 = treated as ALU
//   flush_i         kill the ID instruction this cycle
//   stall_o         hold PC and IF/ID, insert a bubble into ID/EX
//   issue_o         ID instruction advances to EX this cycle
//   long_busy_o     long unit is occupied
//   stall_cycles_o  saturating count of cycles with stall_o = 1
// ----------------------------------------------------------------------------
module pipeline_hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic [1:0]        op_class_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              issue_o,
  output logic              long_busy_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam int MAX_AL  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int MAX_LAT = (MAX_AL > LONG_LAT) ? MAX_AL : LONG_LAT;
  localparam int LAT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [LAT_W-1:0] ALU_L  = LAT_W'(ALU_LAT);
  localparam logic [LAT_W-1:0] LOAD_L = LAT_W'(LOAD_LAT);
  localparam logic [LAT_W-1:0] LONG_L = LAT_W'(LONG_LAT);

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_LONG = 2'd2,
    OP_ALT  = 2'd3
  } opClass_e;

  opClass_e opClass;

  logic [LAT_W-1:0] regCnt_q [NUM_REGS];
  logic [LAT_W-1:0] regCnt_d [NUM_REGS];
  logic [LAT_W-1:0] longCnt_q;
  logic [LAT_W-1:0] longCnt_d;
  logic [CNT_W-1:0] stallCycles_q;
  logic [CNT_W-1:0] stallCycles_d;

  logic [LAT_W-1:0] opLat;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             structHaz;
  logic             anyHazard;
  logic             idLive;

  // Decode the operation class and pick the latency the destination register
  // will carry once this instruction issues. Class 3 is a spare encoding that
  // behaves exactly like an ALU op.
  always_comb begin
    opClass = opClass_e'(op_class_i);
    opLat   = ALU_L;
    unique case (opClass)
      OP_ALU:  opLat = ALU_L;
      OP_LOAD: opLat = LOAD_L;
      OP_LONG: opLat = LONG_L;
      OP_ALT:  opLat = ALU_L;
      default: opLat = ALU_L;
    endcase
  end

  // Hazard detection for the instruction currently in ID. Register 0 is
  // hard-wired to zero and never tracked, so any reference to it is free.
  // The WAW term only fires when the older write would still be outstanding
  // after the younger one completes, which is what would reorder the writes.
  always_comb begin
    raw1      = rs1_used_i && (rs1_addr_i != '0) && (regCnt_q[rs1_addr_i] != '0);
    raw2      = rs2_used_i && (rs2_addr_i != '0) && (regCnt_q[rs2_addr_i] != '0);
    waw       = reg_write_i && (rd_addr_i != '0) && (regCnt_q[rd_addr_i] > opLat);
    structHaz = (opClass == OP_LONG) && (longCnt_q != '0);
    anyHazard = raw1 || raw2 || waw || structHaz;
  end

  // A flushed or reset-time instruction neither stalls nor issues. This
  // keeps a taken branch from freezing the front end on a doomed instruction.
  always_comb begin
    idLive      = id_valid_i && !flush_i && !rst_i;
    stall_o     = idLive && anyHazard;
    issue_o     = idLive && !anyHazard;
    long_busy_o = (longCnt_q != '0);
  end

  // Scoreboard next state. A newly issued write reloads its counter and takes
  // priority over the ordinary countdown. Zero-latency producers never create
  // an entry because forwarding already covers them.
  always_comb begin
    regCnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_o && reg_write_i && (rd_addr_i == ADDR_W'(r)) && (opLat != '0)) begin
        regCnt_d[r] = opLat;
      end else if (regCnt_q[r] != '0) begin
        regCnt_d[r] = regCnt_q[r] - LAT_W'(1);
      end else begin
        regCnt_d[r] = '0;
      end
    end
  end

  // The long unit is not pipelined. Once a long op issues, the unit stays
  // busy for its full latency whether or not the op writes a register.
  always_comb begin
    if (issue_o && (opClass == OP_LONG)) begin
      longCnt_d = LONG_L;
    end else if (longCnt_q != '0) begin
      longCnt_d = longCnt_q - LAT_W'(1);
    end else begin
      longCnt_d = '0;
    end
  end

  // The performance counter sticks at all-ones instead of wrapping. A long
  // profiling run then reads as "at least this many" rather than a small count.
  always_comb begin
    if (stall_o && (stallCycles_q != '1)) begin
      stallCycles_d = stallCycles_q + CNT_W'(1);
    end else begin
      stallCycles_d = stallCycles_q;
    end
    stall_cycles_o = stallCycles_q;
  end

  // State registers with synchronous reset. Reset clears every counter.
  // The cycle after a reset therefore sees no in-flight producers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regCnt_q[r] <= '0;
      end
      longCnt_q     <= '0;
      stallCycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regCnt_q[r] <= regCnt_d[r];
      end
      longCnt_q     <= longCnt_d;
      stallCycles_q <= stallCycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Testbench for pipeline_hazard_scoreboard. Two instances share the same
// stimulus. The main instance uses default parameters. The second has a
// 3-bit stall counter so counter saturation can be observed.
module tb_pipeline_hazard_scoreboard;

  logic       clk_i;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] rs1_addr_i;
  logic [4:0] rs2_addr_i;
  logic       rs1_used_i;
  logic       rs2_used_i;
  logic [4:0] rd_addr_i;
  logic       reg_write_i;
  logic [1:0] op_class_i;
  logic       flush_i;
  logic        stall_o;
  logic        issue_o;
  logic        long_busy_o;
  logic [31:0] stall_cycles_o;
  logic        satStall;
  logic        satIssue;
  logic        satBusy;
  logic [2:0]  satStallCycles;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic [1:0] cls;
    logic       fl;
    logic       rst;
    logic       eStall;
    logic       eIssue;
    logic       eBusy;
  } stim_t;

  typedef struct {
    string name;
    logic  stall;
    logic  issue;
    logic  busy;
  } exp_t;

  exp_t expQ[$];

  pipeline_hazard_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .op_class_i(op_class_i), .flush_i(flush_i),
    .stall_o(stall_o), .issue_o(issue_o), .long_busy_o(long_busy_o),
    .stall_cycles_o(stall_cycles_o)
  );

  pipeline_hazard_scoreboard #(.CNT_W(3)) dutSat (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .op_class_i(op_class_i), .flush_i(flush_i),
    .stall_o(satStall), .issue_o(satIssue), .long_busy_o(satBusy),
    .stall_cycles_o(satStallCycles)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input string n, input logic v,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic we,
                               input logic [1:0] cls, input logic fl,
                               input logic r, input logic es,
                               input logic ei, input logic eb);
    stim_t s;
    s.name = n; s.v = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.we = we; s.cls = cls; s.fl = fl; s.rst = r;
    s.eStall = es; s.eIssue = ei; s.eBusy = eb;
    return s;
  endfunction

  // Drive one cycle of ID inputs and push the expected outputs to the scoreboard.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    id_valid_i  = s.v;
    rs1_addr_i  = s.rs1;
    rs1_used_i  = s.u1;
    rs2_addr_i  = s.rs2;
    rs2_used_i  = s.u2;
    rd_addr_i   = s.rd;
    reg_write_i = s.we;
    op_class_i  = s.cls;
    flush_i     = s.fl;
    rst_i       = s.rst;
    e.name  = s.name;
    e.stall = s.eStall;
    e.issue = s.eIssue;
    e.busy  = s.eBusy;
    expQ.push_back(e);
  endtask

  // Reset both instances and leave time at one unit after a rising edge.
  task automatic resetDut();
    applyStimulus(mk("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    void'(expQ.pop_front());
    @(posedge clk_i); #1;
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    void'(expQ.pop_front());
  endtask

  task automatic test_reset();
    stim_t seq[$];
    exp_t  e;
    applyStimulus(mk("rst0", 1, 7, 1, 0, 0, 8, 1, 2, 0, 1, 0, 0, 0));
    void'(expQ.pop_front());
    @(posedge clk_i); #1;
    seq.push_back(mk("reset_hold", 1, 7, 1, 0, 0, 8, 1, 2, 0, 1, 0, 0, 0));
    seq.push_back(mk("reset_release", 1, 7, 1, 0, 0, 8, 1, 2, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      if (i == 0) begin
        checks++;
        if (stall_cycles_o !== 32'd0 || satStallCycles !== 3'd0) begin
          failures++;
          $display("[TB] FAIL reset_counter: got %0d/%0d want 0/0",
                   stall_cycles_o, satStallCycles);
        end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("lw_x5", 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0));
    seq.push_back(mk("use_x5_stall", 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 0, 0));
    seq.push_back(mk("use_x5_issue", 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd1) begin
      failures++;
      $display("[TB] FAIL load_use_count: got %0d want 1", stall_cycles_o);
    end
  endtask

  task automatic test_alu_chain();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("add_x5", 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 1, 0));
    seq.push_back(mk("add_x6_x5", 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0));
    seq.push_back(mk("alt_x11", 1, 1, 1, 2, 1, 11, 1, 3, 0, 0, 0, 1, 0));
    seq.push_back(mk("use_x11", 1, 11, 1, 11, 1, 12, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL alu_chain_count: got %0d want 0", stall_cycles_o);
    end
  endtask

  task automatic test_long_op();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("mul_x7", 1, 1, 1, 2, 1, 7, 1, 2, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      seq.push_back(mk("sub_x8_x7_stall", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 1, 0, 1));
    seq.push_back(mk("sub_x8_x7_issue", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd4) begin
      failures++;
      $display("[TB] FAIL long_dep_count: got %0d want 4", stall_cycles_o);
    end
  endtask

  task automatic test_back_to_back_long();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("mul_x7", 1, 1, 1, 2, 1, 7, 1, 2, 0, 0, 0, 1, 0));
    seq.push_back(mk("gap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      seq.push_back(mk("mul_x10_struct", 1, 1, 1, 2, 1, 10, 1, 2, 0, 0, 1, 0, 1));
    seq.push_back(mk("mul_x10_issue", 1, 1, 1, 2, 1, 10, 1, 2, 0, 0, 0, 1, 0));
    seq.push_back(mk("busy_after_2nd", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd3) begin
      failures++;
      $display("[TB] FAIL struct_count: got %0d want 3", stall_cycles_o);
    end
  endtask

  task automatic test_waw();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("mul_x9", 1, 1, 1, 2, 1, 9, 1, 2, 0, 0, 0, 1, 0));
    seq.push_back(mk("gap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      seq.push_back(mk("add_x9_waw", 1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 1, 0, 1));
    seq.push_back(mk("add_x9_issue", 1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd3) begin
      failures++;
      $display("[TB] FAIL waw_count: got %0d want 3", stall_cycles_o);
    end
  endtask

  task automatic test_x0_flush();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("lw_x0", 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    seq.push_back(mk("use_x0", 1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 1, 0));
    seq.push_back(mk("lw_x5", 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0));
    seq.push_back(mk("use_x5_flushed", 1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 0, 0, 0));
    seq.push_back(mk("use_x5_after_flush", 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL flush_count: got %0d want 0", stall_cycles_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("mul_x7", 1, 1, 1, 2, 1, 7, 1, 2, 0, 0, 0, 1, 0));
    seq.push_back(mk("dep_stall", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 1, 0, 1));
    seq.push_back(mk("dep_stall", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 1, 0, 1));
    seq.push_back(mk("dep_in_reset", 1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0, 1));
    seq.push_back(mk("dep_after_reset", 1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({stall_o, issue_o, long_busy_o} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 stall_o, issue_o, long_busy_o, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (stall_cycles_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_count: got %0d want 0", stall_cycles_o);
    end
  endtask

  task automatic test_saturation();
    stim_t seq[$];
    exp_t  e;
    resetDut();
    seq.push_back(mk("mul_x7", 1, 1, 1, 2, 1, 7, 1, 2, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      seq.push_back(mk("mul_x8_stall", 1, 7, 1, 2, 1, 8, 1, 2, 0, 0, 1, 0, 1));
    seq.push_back(mk("mul_x8_issue", 1, 7, 1, 2, 1, 8, 1, 2, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      seq.push_back(mk("mul_x9_stall", 1, 8, 1, 2, 1, 9, 1, 2, 0, 0, 1, 0, 1));
    seq.push_back(mk("mul_x9_issue", 1, 8, 1, 2, 1, 9, 1, 2, 0, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++)
      seq.push_back(mk("mul_x10_stall", 1, 9, 1, 2, 1, 10, 1, 2, 0, 0, 1, 0, 1));
    for (int i = 0; i < seq.size(); i++) begin
      applyStimulus(seq[i]);
      #2;
      e = expQ.pop_front();
      checks++;
      if ({satStall, satIssue, satBusy} !== {e.stall, e.issue, e.busy}) begin
        failures++;
        $display("[TB] FAIL %s: got stall/issue/busy=%b%b%b want %b%b%b", e.name,
                 satStall, satIssue, satBusy, e.stall, e.issue, e.busy);
      end
      @(posedge clk_i); #1;
    end
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    void'(expQ.pop_front());
    #1;
    checks++;
    if (stall_cycles_o !== 32'd10) begin
      failures++;
      $display("[TB] FAIL wide_count: got %0d want 10", stall_cycles_o);
    end
    checks++;
    if (satStallCycles !== 3'd7) begin
      failures++;
      $display("[TB] FAIL saturated_count: got %0d want 7", satStallCycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_long_op();
    test_back_to_back_long();
    test_waw();
    test_x0_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
